// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between the byte producers / UART TX engine and uart_tx_arbiter.
// The arbiter takes the master modport; the surrounding logic (requesters and
// engine) takes the slave modport.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Handshake rules:
   //   req_valid[i] rises when requester i has a byte and stays high, with
   //   req_data lane i stable, until the one-cycle req_ack[i] pulse.
   //   req_done[i] later pulses once when that byte has left the engine.
   //   tx_en is a one-cycle launch pulse.
   //   tx_data is valid from the tx_en cycle onward.
   //   tx_done is the engine's one-cycle end-of-frame pulse.
   //   tx_done is only honoured while a frame is outstanding.
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ack;
   logic [NUM_REQ-1:0]   req_done;
   logic                 tx_en;
   logic [7:0]           tx_data;
   logic                 tx_done;
   logic                 busy;
   logic [ID_W-1:0]      grant_id;
   logic                 tx_timeout;

   modport master (
      input  req_valid, req_data, tx_done,
      output req_ack, req_done, tx_en, tx_data, busy, grant_id, tx_timeout
   );

   modport slave (
      output req_valid, req_data, tx_done,
      input  req_ack, req_done, tx_en, tx_data, busy, grant_id, tx_timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte-wide UART TX engine among NUM_REQ
// requesters.
//
// Per-frame sequence:
//   1. IDLE picks a winner and latches its byte.
//   2. LAUNCH pulses tx_en.
//   3. WAIT holds until the engine's tx_done.
//   4. GAP optionally idles for GAP_CYCLES before the next grant.
//
// All outputs are registered.
// Optional watchdog: define UART_TX_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles without tx_done.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 0,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   uart_tx_arbiter_if.master bus,
   output logic [1:0]        state_dbg
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_GAP    = 2'd3
   } state_t;

   // Where a finished (or aborted) frame goes next.
   localparam state_t AFTER_FRAME = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

   // Last value of the gap counter before leaving GAP.
   localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t               state_q, state_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]      grant_q, grant_d;
   logic [7:0]           latch_q, latch_d;
   logic [7:0]           gap_cnt_q, gap_cnt_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic                 tx_en_q, tx_en_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 busy_q;

   // Round-robin scan results.
   logic                 found;
   logic [ID_W-1:0]      winner;
   logic [ID_W-1:0]      cand;

   // Owner after the current one, with wrap at NUM_REQ.
   logic [ID_W-1:0]      next_ptr;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0]          wd_cnt_q, wd_cnt_d;
   logic                 timeout_q, timeout_d;
`endif

   assign next_ptr = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

   // Pick the first pending requester at or above rr_ptr, wrapping modulo
   // NUM_REQ. The requester that just finished therefore ranks last.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
         if (!found && bus.req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // Next-state and next-output logic.
   // Pulse outputs default low; held values default to their current value.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      grant_d   = grant_q;
      latch_d   = latch_q;
      gap_cnt_d = gap_cnt_q;
      ack_d     = '0;
      done_d    = '0;
      tx_en_d   = 1'b0;
      tx_data_d = tx_data_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wd_cnt_d  = wd_cnt_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_d       = winner;
               latch_d       = bus.req_data[{winner, 3'b000} +: 8];
               ack_d[winner] = 1'b1;
               state_d       = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            // tx_done seen here belongs to no frame of ours and is ignored.
            tx_en_d   = 1'b1;
            tx_data_d = latch_q;
            state_d   = S_WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
            wd_cnt_d  = '0;
`endif
         end
         S_WAIT: begin
            if (bus.tx_done) begin
               // Completion wins over a watchdog expiry in the same cycle.
               done_d[grant_q] = 1'b1;
               rr_ptr_d        = next_ptr;
               gap_cnt_d       = '0;
               state_d         = AFTER_FRAME;
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            else if (wd_cnt_q == TO_LAST) begin
               timeout_d = 1'b1;
               rr_ptr_d  = next_ptr;
               gap_cnt_d = '0;
               state_d   = AFTER_FRAME;
            end else begin
               wd_cnt_d = wd_cnt_q + 32'd1;
            end
`endif
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Registers for state, arbitration bookkeeping and every output.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q   <= S_IDLE;
         rr_ptr_q  <= '0;
         grant_q   <= '0;
         latch_q   <= '0;
         gap_cnt_q <= '0;
         ack_q     <= '0;
         done_q    <= '0;
         tx_en_q   <= 1'b0;
         tx_data_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         grant_q   <= grant_d;
         latch_q   <= latch_d;
         gap_cnt_q <= gap_cnt_d;
         ack_q     <= ack_d;
         done_q    <= done_d;
         tx_en_q   <= tx_en_d;
         tx_data_q <= tx_data_d;
         busy_q    <= (state_d != S_IDLE);
      end
   end

`ifdef UART_TX_ARB_TIMEOUT_EN
   // Watchdog counter and its one-cycle error pulse.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wd_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_cnt_q  <= wd_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.tx_timeout = timeout_q;
`else
   assign bus.tx_timeout = 1'b0;
`endif

   assign bus.req_ack  = ack_q;
   assign bus.req_done = done_q;
   assign bus.tx_en    = tx_en_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.busy     = busy_q;
   assign bus.grant_id = grant_q;
   assign state_dbg    = state_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter.
// dut0 runs with GAP_CYCLES=0 and dut1 with GAP_CYCLES=5; both use
// TIMEOUT_CYCLES=100.
// The watchdog sequence runs only when UART_TX_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
   localparam int NR = 4;
   localparam logic [1:0] S_IDLE = 2'd0, S_LAUNCH = 2'd1, S_WAIT = 2'd2;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [1:0] st0, st1;

   uart_tx_arbiter_if #(.NUM_REQ(NR)) bus0 ();
   uart_tx_arbiter_if #(.NUM_REQ(NR)) bus1 ();

   uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(0), .TIMEOUT_CYCLES(100)) dut0 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus0), .state_dbg(st0));
   uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(5), .TIMEOUT_CYCLES(100)) dut1 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus1), .state_dbg(st1));

   // ---------------- clock / reset ----------------
   always #5 sys_clk = ~sys_clk;

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;
   int tx_en_cnt = 0;
   int timeout_cnt = 0;
   int done_cnt[NR];
   logic [9:0] exp_q[$];   // {grant_id, byte} expected at each tx_en of dut0

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic [3:0]  ack;
      logic [1:0]  id;
      logic [7:0]  byte_v;
   } vec_t;
   vec_t vec[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance to the next falling edge and run the dut0 output monitor there.
   task automatic tick();
      logic [9:0] e;
      @(negedge sys_clk);
      if (bus0.tx_en === 1'b1) begin
         tx_en_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL launch_unexpected: got id %0d byte %0h expected none",
                     bus0.grant_id, bus0.tx_data);
         end else begin
            e = exp_q.pop_front();
            check("launch_sb", {22'd0, bus0.grant_id, bus0.tx_data}, {22'd0, e});
         end
      end
      for (int i = 0; i < NR; i++) if (bus0.req_done[i] === 1'b1) done_cnt[i]++;
      if (bus0.tx_timeout === 1'b1) timeout_cnt++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_counts();
      for (int i = 0; i < NR; i++) done_cnt[i] = 0;
      tx_en_cnt = 0;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      bus0.req_valid = '0;
      bus0.tx_done = 1'b0;
      bus1.req_valid = '0;
      bus1.tx_done = 1'b0;
      tick();
      tick();
      sys_rst = 1'b0;
   endtask

   task automatic pulse_done0();
      bus0.tx_done = 1'b1;
      tick();
      bus0.tx_done = 1'b0;
   endtask

   task automatic wait_tx_en0(input int budget);
      int n = 0;
      do begin
         tick();
         n++;
      end while (bus0.tx_en !== 1'b1 && n < budget);
      if (bus0.tx_en !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL tx_en_wait: got no tx_en expected one within %0d cycles", budget);
      end
   endtask

   // Overall time limit.
   initial begin
      #500000;
      $display("FAIL sim_watchdog: got no completion expected finish before limit");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int spacing;
      int k;

      // Vectors from a fresh reset (rr_ptr=0), applied back to back.
      vec[0] = '{4'b0100, 32'h11_A5_22_33, 4'b0100, 2'd2, 8'hA5};
      vec[1] = '{4'b1111, 32'h4D_3C_2B_1A, 4'b1000, 2'd3, 8'h4D};
      vec[2] = '{4'b0011, 32'h88_77_66_55, 4'b0001, 2'd0, 8'h55};
      vec[3] = '{4'b0001, 32'h00_00_00_C3, 4'b0001, 2'd0, 8'hC3};
      vec[4] = '{4'b1001, 32'hF0_0F_E1_1E, 4'b1000, 2'd3, 8'hF0};
      vec[5] = '{4'b0110, 32'h9A_BC_DE_F0, 4'b0010, 2'd1, 8'hDE};
      vec[6] = '{4'b1011, 32'h12_34_56_78, 4'b1000, 2'd3, 8'h12};
      vec[7] = '{4'b1000, 32'h7E_00_00_00, 4'b1000, 2'd3, 8'h7E};

      bus0.req_valid = '0;
      bus0.req_data  = '0;
      bus0.tx_done   = 1'b0;
      bus1.req_valid = '0;
      bus1.req_data  = '0;
      bus1.tx_done   = 1'b0;
      clear_counts();
      do_reset();

      // ---- reset values ----
      check("rst_ack",     bus0.req_ack, 0);
      check("rst_done",    bus0.req_done, 0);
      check("rst_tx_en",   bus0.tx_en, 0);
      check("rst_tx_data", bus0.tx_data, 0);
      check("rst_busy",    bus0.busy, 0);
      check("rst_grant",   bus0.grant_id, 0);
      check("rst_timeout", bus0.tx_timeout, 0);
      check("rst_state",   st0, S_IDLE);

      // ---- table-driven single grants ----
      for (int v = 0; v < 8; v++) begin
         bus0.req_valid = vec[v].valid;
         bus0.req_data  = vec[v].data;
         exp_q.push_back({vec[v].id, vec[v].byte_v});
         tick();
         check("vec_ack",   bus0.req_ack, vec[v].ack);
         check("vec_grant", bus0.grant_id, vec[v].id);
         check("vec_busy",  bus0.busy, 1);
         bus0.req_valid = '0;
         tick();
         check("vec_tx_en",   bus0.tx_en, 1);
         check("vec_tx_data", bus0.tx_data, vec[v].byte_v);
         repeat ($urandom_range(1, 5)) tick();
         check("vec_no_early_done", bus0.req_done, 0);
         pulse_done0();
         check("vec_done",    bus0.req_done, vec[v].ack);
         check("vec_idle",    bus0.busy, 0);
         check("vec_tx_hold", bus0.tx_data, vec[v].byte_v);
      end

      // ---- round-robin fairness: all four held for 8 frames ----
      do_reset();
      clear_counts();
      bus0.req_data  = 32'hD3_C2_B1_A0;
      bus0.req_valid = 4'b1111;
      for (int f = 0; f < 8; f++) begin
         exp_q.push_back({2'(f % 4), 8'(8'hA0 + 8'h11 * (f % 4))});
      end
      for (int f = 0; f < 8; f++) begin
         wait_tx_en0(10);
         repeat ($urandom_range(1, 4)) tick();
         bus0.tx_done = 1'b1;
         tick();
         bus0.tx_done = 1'b0;
         if (f == 7) bus0.req_valid = '0;
      end
      repeat (4) tick();
      for (int i = 0; i < NR; i++) check("rr_done_count", done_cnt[i], 2);
      check("rr_launches", tx_en_cnt, 8);
      check("rr_sb_empty", exp_q.size(), 0);

      // ---- stray tx_done in IDLE and in LAUNCH ----
      clear_counts();
      bus0.tx_done = 1'b1;
      tick();
      bus0.tx_done = 1'b0;
      check("stray_idle_done",  bus0.req_done, 0);
      check("stray_idle_state", st0, S_IDLE);
      check("stray_idle_busy",  bus0.busy, 0);
      bus0.req_data  = 32'h00_00_5A_00;
      bus0.req_valid = 4'b0010;
      exp_q.push_back({2'd1, 8'h5A});
      tick();
      check("stray_launch_state", st0, S_LAUNCH);
      bus0.req_valid = '0;
      bus0.tx_done   = 1'b1;
      tick();
      bus0.tx_done = 1'b0;
      check("stray_launch_done",  bus0.req_done, 0);
      check("stray_launch_wait",  st0, S_WAIT);
      repeat (4) tick();
      check("stray_still_wait",   st0, S_WAIT);
      check("stray_no_done_cnt",  done_cnt[1], 0);
      check("stray_one_launch",   tx_en_cnt, 1);
      pulse_done0();
      check("stray_real_done",    bus0.req_done, 4'b0010);

      // ---- reset while in WAIT with grant_id=3 (rr_ptr is 2 beforehand) ----
      clear_counts();
      bus0.req_data  = 32'hC7_00_00_00;
      bus0.req_valid = 4'b1000;
      exp_q.push_back({2'd3, 8'hC7});
      tick();
      bus0.req_valid = '0;
      tick();
      tick();
      check("mid_wait_state", st0, S_WAIT);
      check("mid_wait_grant", bus0.grant_id, 3);
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      check("mid_rst_ack",     bus0.req_ack, 0);
      check("mid_rst_done",    bus0.req_done, 0);
      check("mid_rst_tx_en",   bus0.tx_en, 0);
      check("mid_rst_tx_data", bus0.tx_data, 0);
      check("mid_rst_busy",    bus0.busy, 0);
      check("mid_rst_grant",   bus0.grant_id, 0);
      check("mid_rst_state",   st0, S_IDLE);
      repeat (3) tick();
      check("mid_rst_no_done", done_cnt[3], 0);
      bus0.req_data  = 32'h63_00_61_00;
      bus0.req_valid = 4'b1010;
      exp_q.push_back({2'd1, 8'h61});
      tick();
      check("post_rst_ack",   bus0.req_ack, 4'b0010);
      check("post_rst_grant", bus0.grant_id, 1);
      bus0.req_valid = '0;
      wait_tx_en0(5);
      repeat (2) tick();
      pulse_done0();
      check("post_rst_done", bus0.req_done, 4'b0010);

      // ---- gap timing on dut1 (GAP_CYCLES=5) ----
      bus1.req_data  = 32'h00_00_1B_0A;
      bus1.req_valid = 4'b0011;
      tick();
      check("gap_ack0", bus1.req_ack, 4'b0001);
      bus1.req_valid = 4'b0010;
      k = 0;
      while (bus1.tx_en !== 1'b1 && k < 10) begin
         tick();
         k++;
      end
      check("gap_first_tx_en",   bus1.tx_en, 1);
      check("gap_first_tx_data", bus1.tx_data, 8'h0A);
      repeat (3) tick();
      bus1.tx_done = 1'b1;
      tick();
      bus1.tx_done = 1'b0;
      check("gap_done0", bus1.req_done, 4'b0001);
      k = 1;
      spacing = 0;
      while (k < 20 && spacing == 0) begin
         if (bus1.tx_en === 1'b1) begin
            spacing = k;
         end else begin
            if (k <= 5) check("gap_busy", bus1.busy, 1);
            tick();
            k++;
         end
      end
      bus1.req_valid = '0;
      check("gap_spacing", spacing, 8);
      check("gap_grant1",  bus1.grant_id, 1);
      check("gap_data1",   bus1.tx_data, 8'h1B);
      repeat (2) tick();
      bus1.tx_done = 1'b1;
      tick();
      bus1.tx_done = 1'b0;
      check("gap_done1", bus1.req_done, 4'b0010);

`ifdef UART_TX_ARB_TIMEOUT_EN
      // ---- watchdog: no tx_done after a grant to requester 2 ----
      do_reset();
      clear_counts();
      timeout_cnt = 0;
      bus0.req_data  = 32'h00_E2_00_00;
      bus0.req_valid = 4'b0100;
      exp_q.push_back({2'd2, 8'hE2});
      tick();
      bus0.req_valid = '0;
      wait_tx_en0(5);
      k = 0;
      while (bus0.tx_timeout !== 1'b1 && k < 150) begin
         tick();
         k++;
      end
      check("to_latency",  k, 100);
      check("to_no_done",  done_cnt[2], 0);
      tick();
      check("to_one_pulse", timeout_cnt, 1);
      check("to_idle",      st0, S_IDLE);
      bus0.req_data  = 32'h33_22_11_00;
      bus0.req_valid = 4'b1111;
      exp_q.push_back({2'd3, 8'h33});
      tick();
      check("to_next_grant", bus0.grant_id, 3);
      bus0.req_valid = '0;
      wait_tx_en0(5);
      pulse_done0();
      check("to_next_done", bus0.req_done, 4'b1000);
`else
      check("no_timeout_pulses", timeout_cnt, 0);
`endif

      repeat (3) tick();
      check("final_sb_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
